// File: rtl/lut_ff_mux_pkg.sv
// Shared types and helpers for the multi-channel LUT/FF/mux fabric benchmark.
package lut_ff_mux_pkg;

  typedef enum logic [1:0] {
    UNCFG   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } cfg_state_t;

  // Total configuration length: per channel a 2**k-entry table plus one inversion bit.
  function automatic int unsigned cfg_len(input int unsigned k, input int unsigned ch);
    return ch * ((32'd1 << k) + 32'd1);
  endfunction

endpackage

// File: rtl/lut_ff_cell.sv
// One fabric channel: K-input LUT with output inversion, gated FF and comb/reg output mux.
module lut_ff_cell
  import lut_ff_mux_pkg::*;
#(
  parameter int unsigned K = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [(2**K)-1:0]   table_bits,
  input  logic                inv,
  input  logic                cfg_done,
  input  logic                clr,
  input  logic                ce,
  input  logic [K-1:0]        sel,
  input  logic                mux_sel,
  output logic                q
);

  logic lut_c;
  logic ff_q;

  assign lut_c = table_bits[sel] ^ inv;

  // FF is forced to zero whenever the configuration is not complete, so the first READY cycle sees 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= 1'b0;
    end else if (!cfg_done || clr) begin
      ff_q <= 1'b0;
    end else if (ce) begin
      ff_q <= lut_c;
    end
  end

  assign q = cfg_done ? (mux_sel ? ff_q : lut_c) : 1'b0;

endmodule

// File: rtl/lut_ff_mux_array.sv
// CH-channel LUT/FF/mux array with a serial configuration chain and load FSM.
module lut_ff_mux_array
  import lut_ff_mux_pkg::*;
#(
  parameter int unsigned K  = 4,
  parameter int unsigned CH = 4
) (
  input  logic              clk,
  input  logic              global_resetn,
  input  logic              cfg_en,
  input  logic              cfg_din,
  output logic              cfg_done,
  input  logic              clr,
  input  logic [CH-1:0]     ce,
  input  logic [CH*K-1:0]   in,
  input  logic [CH-1:0]     mux_sel,
  output logic [CH-1:0]     q
);

  localparam int unsigned TW = 2**K;
  localparam int unsigned FW = TW + 1;
  localparam int unsigned L  = cfg_len(K, CH);
  localparam int unsigned CW = $clog2(L + 1);

  cfg_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [L-1:0]    cfg_q;
  logic            shift_c;
  logic            done_q;

  // Load FSM: any gap in cfg_en during a load aborts it; cfg_en from READY starts a reload.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_c = 1'b0;
    case (state_q)
      UNCFG, READY: begin
        if (cfg_en) begin
          shift_c = 1'b1;
          cnt_d   = CW'(1);
          state_d = LOADING;
        end
      end
      LOADING: begin
        if (cfg_en) begin
          shift_c = 1'b1;
          if (cnt_q == CW'(L - 1)) begin
            cnt_d   = '0;
            state_d = READY;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d   = '0;
          state_d = UNCFG;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = UNCFG;
      end
    endcase
  end

  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      state_q <= UNCFG;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d == READY);
      if (shift_c) begin
        cfg_q <= {cfg_din, cfg_q[L-1:1]};
      end
    end
  end

  assign cfg_done = done_q;

  // Channel c reads table bits [b +: 2**K] and the inversion bit at b + 2**K.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    lut_ff_cell #(.K(K)) u_cell (
      .clk        (clk),
      .rst_n      (global_resetn),
      .table_bits (cfg_q[c*FW +: TW]),
      .inv        (cfg_q[c*FW + TW]),
      .cfg_done   (done_q),
      .clr        (clr),
      .ce         (ce[c]),
      .sel        (in[c*K +: K]),
      .mux_sel    (mux_sel[c]),
      .q          (q[c])
    );
  end

endmodule

// File: tb/tb_lut_ff_mux_array.sv
// Scoreboard bench for lut_ff_mux_array (K=4, CH=4) against a bit-queue reference model.
module tb_lut_ff_mux_array;

  localparam int K  = 4;
  localparam int CH = 4;
  localparam int FW = (2**K) + 1;
  localparam int L  = CH * FW;

  logic            clk = 1'b0;
  logic            global_resetn;
  logic            cfg_en;
  logic            cfg_din;
  logic            cfg_done;
  logic            clr;
  logic [CH-1:0]   ce;
  logic [CH*K-1:0] in_v;
  logic [CH-1:0]   mux_sel;
  logic [CH-1:0]   q;

  always #5 clk = ~clk;

  lut_ff_mux_array #(.K(K), .CH(CH)) dut (
    .clk           (clk),
    .global_resetn (global_resetn),
    .cfg_en        (cfg_en),
    .cfg_din       (cfg_din),
    .cfg_done      (cfg_done),
    .clr           (clr),
    .ce            (ce),
    .in            (in_v),
    .mux_sel       (mux_sel),
    .q             (q)
  );

  logic [4:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: the bits of the current load are kept in send order.
  bit        m_load[$];
  bit        m_loading;
  bit        m_done;
  bit [15:0] m_tab[CH];
  bit        m_inv[CH];
  bit        m_ff[CH];

  function automatic bit m_lut(int c, logic [CH*K-1:0] iv);
    logic [3:0] a;
    a = iv[c*K +: K];
    return m_tab[c][a] ^ m_inv[c];
  endfunction

  function automatic logic [4:0] m_out(logic [CH*K-1:0] iv, logic [CH-1:0] sel);
    logic [3:0] o;
    for (int c = 0; c < CH; c++)
      o[c] = m_done ? (sel[c] ? m_ff[c] : m_lut(c, iv)) : 1'b0;
    return {m_done, o};
  endfunction

  task automatic m_edge(logic en, logic din, logic clr_i, logic [CH-1:0] ce_i,
                        logic [CH*K-1:0] iv);
    for (int c = 0; c < CH; c++) begin
      if (!m_done || clr_i) m_ff[c] = 1'b0;
      else if (ce_i[c])     m_ff[c] = m_lut(c, iv);
    end
    if (en) begin
      if (!m_loading) begin
        m_load.delete();
        m_loading = 1'b1;
        m_done    = 1'b0;
      end
      m_load.push_back(din);
      if (m_load.size() == L) begin
        for (int c = 0; c < CH; c++) begin
          for (int i = 0; i < 16; i++) m_tab[c][i] = m_load[c*FW + i];
          m_inv[c] = m_load[c*FW + 16];
        end
        m_done    = 1'b1;
        m_loading = 1'b0;
      end
    end else if (m_loading) begin
      m_loading = 1'b0;
      m_done    = 1'b0;
    end
  endtask

  task automatic m_reset();
    m_load.delete();
    m_loading = 1'b0;
    m_done    = 1'b0;
    for (int c = 0; c < CH; c++) begin
      m_ff[c]  = 1'b0;
      m_tab[c] = '0;
      m_inv[c] = 1'b0;
    end
  endtask

  task automatic step(logic en, logic din, logic clr_i, logic [CH-1:0] ce_i,
                      logic [CH*K-1:0] iv, logic [CH-1:0] sel);
    global_resetn = 1'b1;
    cfg_en  = en;
    cfg_din = din;
    clr     = clr_i;
    ce      = ce_i;
    in_v    = iv;
    mux_sel = sel;
    exp_q.push_back(m_out(iv, sel));
    @(posedge clk);
    m_edge(en, din, clr_i, ce_i, iv);
    #1;
  endtask

  task automatic rand_step(logic en, logic din);
    step(en, din, ($urandom_range(0, 7) == 0), CH'($urandom), (CH*K)'($urandom),
         CH'($urandom));
  endtask

  // Reset is asserted mid-cycle; outputs must drop before the next edge.
  task automatic reset_step(logic [CH*K-1:0] iv, logic [CH-1:0] sel);
    global_resetn = 1'b0;
    cfg_en  = 1'($urandom);
    cfg_din = 1'($urandom);
    clr     = 1'b0;
    ce      = CH'($urandom);
    in_v    = iv;
    mux_sel = sel;
    m_reset();
    exp_q.push_back(5'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(logic [L-1:0] v, int n);
    for (int j = 0; j < n; j++) rand_step(1'b1, v[j]);
  endtask

  task automatic full_load_checks();
    step(1'b0, 1'b0, 1'b0, 4'h0, 16'h0001, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 16'h0003, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 16'h5a5a, 4'h0);
  endtask

  // Monitor: outputs sampled on the falling edge, one expectation per cycle.
  initial begin
    logic [4:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({cfg_done, q} !== e) begin
          n_fail++;
          $display("FAIL cyc%0d {cfg_done,q}: got %b expected %b", cyc, {cfg_done, q}, e);
        end
      end
    end
  end

  initial begin
    logic [L-1:0] v_ref;
    logic [L-1:0] v_rnd;

    global_resetn = 1'b0;
    cfg_en = 1'b0; cfg_din = 1'b0; clr = 1'b0;
    ce = '0; in_v = '0; mux_sel = '0;
    m_reset();
    @(posedge clk); #1;

    // Reset and unconfigured behaviour.
    reset_step(16'h1234, 4'h5);
    reset_step(16'hffff, 4'h0);
    for (int i = 0; i < 6; i++) rand_step(1'b0, 1'b0);

    // Reference config: ch0 = 6996 inv0, ch1 = 0 inv1, others zero.
    v_ref = '0;
    v_ref[15:0]  = 16'h6996;
    v_ref[FW+16] = 1'b1;
    send_bits(v_ref, L);
    full_load_checks();

    // Registered path, enable hold and clear.
    step(1'b0, 1'b0, 1'b0, 4'h1, 16'h0001, 4'h1);
    step(1'b0, 1'b0, 1'b0, 4'h1, 16'h0003, 4'h1);
    step(1'b0, 1'b0, 1'b0, 4'h1, 16'h0001, 4'h1);
    step(1'b0, 1'b0, 1'b0, 4'h0, 16'h0003, 4'h1);
    step(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 4'h1);
    step(1'b0, 1'b0, 1'b1, 4'h1, 16'h0001, 4'h1);
    step(1'b0, 1'b0, 1'b0, 4'h0, 16'h0001, 4'h1);
    step(1'b0, 1'b0, 1'b1, 4'h1, 16'h0001, 4'h0);

    // Abort after 30 bits, then a fresh full load.
    v_rnd = {$urandom, $urandom, $urandom};
    send_bits(v_rnd, 30);
    for (int i = 0; i < 3; i++) rand_step(1'b0, 1'b0);
    send_bits(v_ref, L);
    full_load_checks();

    // Reconfigure from READY, abort it, reload.
    send_bits(v_rnd, 5);
    rand_step(1'b0, 1'b0);
    send_bits(v_ref, L);
    full_load_checks();

    // Reset at bit 40 of a load.
    send_bits(v_rnd, 40);
    reset_step(16'h0001, 4'h0);
    for (int i = 0; i < 3; i++) rand_step(1'b0, 1'b0);

    // Reset while READY with a live combinational 1 on q[0].
    send_bits(v_ref, L);
    step(1'b0, 1'b0, 1'b0, 4'hf, 16'h0001, 4'h0);
    reset_step(16'h0001, 4'h0);
    rand_step(1'b0, 1'b0);

    // Randomized loads with occasional reconfigure/abort traffic.
    for (int r = 0; r < 20; r++) begin
      v_rnd = {$urandom, $urandom, $urandom};
      send_bits(v_rnd, L);
      for (int i = 0; i < 30; i++)
        rand_step(($urandom_range(0, 15) == 0), 1'($urandom));
    end

    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
